// File: rtl/sipo_pkg.sv
// Constants shared between the serializer and deserializer sides of the link.
package sipo_pkg;

  localparam int DESER_WIDTH_DEF = 4;
  localparam bit MSB_FIRST       = 1'b1;

  // Bit-counter width for a word of w bits (ceil(log2(w))).
  function automatic int cnt_w_of(input int w);
    int n;
    n = 0;
    while ((32'sd1 <<< n) < w) begin
      n = n + 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/deser_bit_cnt.sv
// Modulo-WIDTH bit counter with enable, synchronous clear and terminal-count flag.
module deser_bit_cnt #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tc_o = (cnt_q == CNT_W'(WIDTH - 1));

  // Next count: clear wins, then wrap at terminal count.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      if (tc_o) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sipo_deser.sv
// Serial-to-parallel deserializer with a one-entry valid/ready output register
// and a sticky overrun flag for words completed while the holding slot is full.
module sipo_deser
  import sipo_pkg::*;
#(
  parameter  int WIDTH = DESER_WIDTH_DEF,
  localparam int CNT_W = cnt_w_of(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             sin,
  input  logic             sin_valid,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             overrun,
  output logic             busy
);

  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             overrun_q, overrun_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] shift_s;
  logic             tc_s;
  logic             complete_s;

  deser_bit_cnt #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_bit_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (clr),
    .en_i  (sin_valid),
    .tc_o  (tc_s)
  );

  assign shift_s    = MSB_FIRST ? {sr_q[WIDTH-2:0], sin} : {sin, sr_q[WIDTH-1:1]};
  assign complete_s = sin_valid && !clr && tc_s;

  // Next state for shifter, holding register, overrun and busy.
  always_comb begin
    sr_d         = sr_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    overrun_d    = overrun_q;
    busy_d       = busy_q;
    if (clr) begin
      sr_d   = '0;
      busy_d = 1'b0;
    end else if (sin_valid) begin
      sr_d   = shift_s;
      busy_d = !tc_s;
    end else begin
      sr_d   = sr_q;
      busy_d = busy_q;
    end
    // A completion may reuse the slot only if it is empty or draining now.
    if (complete_s) begin
      if (!dout_valid_q || dout_ready) begin
        dout_d       = shift_s;
        dout_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (dout_valid_q && dout_ready) begin
      dout_valid_d = 1'b0;
    end else begin
      dout_valid_d = dout_valid_q;
    end
    if (clr) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_d;
    end
  end

  // State registers; every output is driven straight from one of these.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_q         <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      sr_q         <= sr_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      overrun_q    <= overrun_d;
      busy_q       <= busy_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign overrun    = overrun_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_sipo_deser.sv
// Directed self-checking bench for sipo_deser (WIDTH=4, MSB-first).
module tb_sipo_deser;

  logic       clk;
  logic       rst;
  logic       clr;
  logic       sin;
  logic       sin_valid;
  logic [3:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic       overrun;
  logic       busy;

  int checks;
  int errors;

  sipo_deser #(.WIDTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .sin        (sin),
    .sin_valid  (sin_valid),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .overrun    (overrun),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    sin       = b;
    sin_valid = 1'b1;
    tick();
    sin_valid = 1'b0;
  endtask

  task automatic send_word(input logic [3:0] w);
    for (int i = 3; i >= 0; i--) begin
      send_bit(w[i]);
    end
  endtask

  task automatic test_reset();
    checks++; if (dout !== 4'b0000) begin errors++; $display("FAIL reset_dout got %b exp %b", dout, 4'b0000); end
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", dout_valid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b exp 0", overrun); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    send_bit(1'b1);
    send_bit(1'b0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midword_busy got %b exp 1", busy); end
    #2 rst = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL async_reset_busy got %b exp 0", busy); end
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL async_reset_valid got %b exp 0", dout_valid); end
    #1 rst = 1'b1;
    tick();
    dout_ready = 1'b0;
    send_word(4'b1011);
    checks++; if (dout !== 4'b1011) begin errors++; $display("FAIL post_reset_word got %b exp %b", dout, 4'b1011); end
    checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL post_reset_valid got %b exp 1", dout_valid); end
    dout_ready = 1'b1;
    tick();
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL drain_valid got %b exp 0", dout_valid); end
    checks++; if (dout !== 4'b1011) begin errors++; $display("FAIL drain_hold got %b exp %b", dout, 4'b1011); end
  endtask

  task automatic test_gapped();
    logic [3:0] w;
    int pulses;
    w = 4'b0110;
    pulses = 0;
    dout_ready = 1'b1;
    for (int i = 3; i >= 0; i--) begin
      send_bit(w[i]);
      if (dout_valid === 1'b1) pulses++;
      if (i != 0) begin
        for (int g = 0; g < 3; g++) begin
          checks++; if (busy !== 1'b1) begin errors++; $display("FAIL gap_busy bit %0d got %b exp 1", 3 - i, busy); end
          tick();
          if (dout_valid === 1'b1) pulses++;
        end
      end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL gap_busy_end got %b exp 0", busy); end
    checks++; if (dout !== 4'b0110) begin errors++; $display("FAIL gap_word got %b exp %b", dout, 4'b0110); end
    for (int g = 0; g < 3; g++) begin
      tick();
      if (dout_valid === 1'b1) pulses++;
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL gap_pulses got %0d exp 1", pulses); end
  endtask

  task automatic test_back_to_back();
    dout_ready = 1'b1;
    send_word(4'b1100);
    checks++; if (dout !== 4'b1100 || dout_valid !== 1'b1) begin errors++; $display("FAIL b2b_word1 got %b/%b exp 1100/1", dout, dout_valid); end
    send_bit(1'b1);
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b exp 0", dout_valid); end
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    checks++; if (dout !== 4'b1010 || dout_valid !== 1'b1) begin errors++; $display("FAIL b2b_word2 got %b/%b exp 1010/1", dout, dout_valid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun got %b exp 0", overrun); end
    tick();
  endtask

  task automatic test_overrun();
    dout_ready = 1'b0;
    send_word(4'b1001);
    send_word(4'b0111);
    checks++; if (dout !== 4'b1001) begin errors++; $display("FAIL ovr_dout got %b exp %b", dout, 4'b1001); end
    checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid got %b exp 1", dout_valid); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag got %b exp 1", overrun); end
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
    checks++; if (dout_valid !== 1'b0 || overrun !== 1'b1) begin errors++; $display("FAIL ovr_after_drain got v=%b o=%b exp v=0 o=1", dout_valid, overrun); end
  endtask

  task automatic test_clr();
    dout_ready = 1'b1;
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    checks++; if (busy !== 1'b1 || overrun !== 1'b1) begin errors++; $display("FAIL clr_pre got b=%b o=%b exp b=1 o=1", busy, overrun); end
    clr = 1'b1;
    send_bit(1'b1);
    clr = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clr_busy got %b exp 0", busy); end
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL clr_no_word got %b exp 0", dout_valid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL clr_overrun got %b exp 0", overrun); end
    dout_ready = 1'b0;
    send_word(4'b0101);
    checks++; if (dout !== 4'b0101 || dout_valid !== 1'b1) begin errors++; $display("FAIL clr_next_word got %b/%b exp 0101/1", dout, dout_valid); end
  endtask

  task automatic test_simultaneous();
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
    send_word(4'b0001);
    checks++; if (dout !== 4'b0001 || dout_valid !== 1'b1) begin errors++; $display("FAIL sim_first got %b/%b exp 0001/1", dout, dout_valid); end
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    dout_ready = 1'b1;
    send_bit(1'b0);
    dout_ready = 1'b0;
    checks++; if (dout !== 4'b1110) begin errors++; $display("FAIL sim_dout got %b exp %b", dout, 4'b1110); end
    checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL sim_valid got %b exp 1", dout_valid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL sim_overrun got %b exp 0", overrun); end
    tick();
    checks++; if (dout !== 4'b1110 || dout_valid !== 1'b1) begin errors++; $display("FAIL sim_stall got %b/%b exp 1110/1", dout, dout_valid); end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b0;
    clr        = 1'b0;
    sin        = 1'b0;
    sin_valid  = 1'b0;
    dout_ready = 1'b0;
    #12;
    test_reset_entry();
    test_gapped();
    test_back_to_back();
    test_overrun();
    test_clr();
    test_simultaneous();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Sample reset state while rst is low, then release and run the reset scenario.
  task automatic test_reset_entry();
    checks++; if (dout_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL in_reset got v=%b b=%b exp 0/0", dout_valid, busy); end
    rst = 1'b1;
    tick();
    test_reset();
  endtask

endmodule
